// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD sequencer: FSM encoding, default widths and
// the watchdog sizing helper.
package gcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RELEASE,
        ST_OUTPUT,
        ST_FAULT
    } state_t;

    localparam int unsigned GCD_W       = 8;
    localparam int unsigned GCD_TIMEOUT = 600;
    localparam int unsigned GCD_WD_W    = $clog2(GCD_TIMEOUT + 1);

    function automatic int unsigned wdWidth(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/gcd_fifo.sv
// Synchronous operand FIFO; pointers carry one extra wrap bit so full and
// empty can be told apart without a separate occupancy counter.
module gcd_fifo #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wrPtr_q;
    logic [AW:0]  rdPtr_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         doPush;
    logic         doPop;

    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge Clk) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= wdata;
    end

    assign rdata = mem_q[rdPtr_q[AW-1:0]];
    assign empty = (wrPtr_q == rdPtr_q);
    assign full  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

endmodule

// File: rtl/gcd_sequencer.sv
// Queues operand pairs, feeds them to the euclid engine over a four-phase
// start/ack handshake, and returns results in order behind a watchdog.
module gcd_sequencer
    import gcd_pkg::*;
#(
    parameter int unsigned W       = GCD_W,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = GCD_TIMEOUT
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         start,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    input  logic         ack,
    input  logic [W-1:0] y,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res,
    output logic         err,
    output logic         busy
);

    localparam int unsigned WD_W = wdWidth(TIMEOUT);

    state_t          state_q, state_d;
    logic [W-1:0]    opA_q, opA_d;
    logic [W-1:0]    opB_q, opB_d;
    logic [W-1:0]    res_q, res_d;
    logic            err_q, err_d;
    logic            faultPend_q, faultPend_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [WD_W-1:0] wdNext;
    logic            timeoutHit;

    logic            fifoPush;
    logic            fifoPop;
    logic            fifoFull;
    logic            fifoEmpty;
    logic [2*W-1:0]  fifoData;
    logic [W-1:0]    headA;
    logic [W-1:0]    headB;

    assign fifoPush = in_valid && in_ready;
    assign headA    = fifoData[2*W-1:W];
    assign headB    = fifoData[W-1:0];

    gcd_fifo #(
        .W     (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .push  (fifoPush),
        .pop   (fifoPop),
        .wdata ({in_a, in_b}),
        .rdata (fifoData),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            opA_q       <= '0;
            opB_q       <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            faultPend_q <= 1'b0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            opA_q       <= opA_d;
            opB_q       <= opB_d;
            res_q       <= res_d;
            err_q       <= err_d;
            faultPend_q <= faultPend_d;
            wd_q        <= wd_d;
        end
    end

    assign wdNext     = wd_q + 1'b1;
    assign timeoutHit = (wdNext == WD_W'(TIMEOUT));

    // A new pair is only taken while ack is low, so a stale ack left over
    // from an engine that was mid-run at reset is never mistaken for ours.
    always_comb begin
        state_d     = state_q;
        opA_d       = opA_q;
        opB_d       = opB_q;
        res_d       = res_q;
        err_d       = err_q;
        faultPend_d = faultPend_q;
        wd_d        = wd_q;
        fifoPop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifoEmpty && !ack) begin
                    fifoPop = 1'b1;
                    if (headA == '0 || headB == '0) begin
                        res_d   = headA | headB;
                        state_d = ST_OUTPUT;
                    end else begin
                        opA_d   = headA;
                        opB_d   = headB;
                        wd_d    = '0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                wd_d = wdNext;
                if (ack) begin
                    res_d   = y;
                    state_d = ST_RELEASE;
                end else if (timeoutHit) begin
                    res_d       = '0;
                    err_d       = 1'b1;
                    faultPend_d = 1'b1;
                    state_d     = ST_FAULT;
                end
            end
            ST_RELEASE: begin
                wd_d = wdNext;
                if (!ack) begin
                    state_d = ST_OUTPUT;
                end else if (timeoutHit) begin
                    res_d       = '0;
                    err_d       = 1'b1;
                    faultPend_d = 1'b1;
                    state_d     = ST_FAULT;
                end
            end
            ST_OUTPUT: begin
                if (res_ready) state_d = ST_IDLE;
            end
            ST_FAULT: begin
                if (faultPend_q && res_ready) faultPend_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start     = (state_q == ST_ISSUE);
        res_valid = (state_q == ST_OUTPUT) || (state_q == ST_FAULT && faultPend_q);
        in_ready  = !fifoFull && (state_q != ST_FAULT);
        busy      = (state_q != ST_IDLE) || !fifoEmpty;
    end

    assign op_a = opA_q;
    assign op_b = opB_q;
    assign res  = res_q;
    assign err  = err_q;

endmodule

// File: tb/tb_gcd_sequencer.sv
// Bench for gcd_sequencer: a behavioural subtractive engine on one instance,
// a never-acking stub with a short watchdog on a second.
module tb_gcd_sequencer;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       ack = 1'b0;
    logic [7:0] y = '0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res;
    logic       err;
    logic       busy;

    logic       in_valid2 = 1'b0;
    logic       in_ready2;
    logic [7:0] in_a2 = '0;
    logic [7:0] in_b2 = '0;
    logic       start2;
    logic [7:0] op_a2;
    logic [7:0] op_b2;
    logic       ack2 = 1'b0;
    logic [7:0] y2 = '0;
    logic       res_valid2;
    logic       res_ready2 = 1'b0;
    logic [7:0] res2;
    logic       err2;
    logic       busy2;

    logic [7:0] engA = '0;
    logic [7:0] engB = '0;
    logic       engBusy = 1'b0;
    logic       engHold = 1'b0;

    int         checkCount = 0;
    int         passCount = 0;
    logic [7:0] expQ[$];

    always #5 Clk = ~Clk;

    gcd_sequencer #(.W(8), .DEPTH(4), .TIMEOUT(600)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .start(start), .op_a(op_a), .op_b(op_b), .ack(ack), .y(y),
        .res_valid(res_valid), .res_ready(res_ready), .res(res),
        .err(err), .busy(busy)
    );

    gcd_sequencer #(.W(8), .DEPTH(4), .TIMEOUT(16)) dutWd (
        .Clk(Clk), .Rst_n(Rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_a(in_a2), .in_b(in_b2),
        .start(start2), .op_a(op_a2), .op_b(op_b2), .ack(ack2), .y(y2),
        .res_valid(res_valid2), .res_ready(res_ready2), .res(res2),
        .err(err2), .busy(busy2)
    );

    // Subtractive engine with no reset; engHold pins ack high to mimic an
    // engine that finished while the sequencer was in reset.
    always @(posedge Clk) begin
        if (engBusy) begin
            if (engA == engB) begin
                y       <= engA;
                ack     <= 1'b1;
                engBusy <= 1'b0;
            end else if (engA > engB) begin
                engA <= engA - engB;
            end else begin
                engB <= engB - engA;
            end
        end else if (ack) begin
            if (!start && !engHold) ack <= 1'b0;
        end else if (start) begin
            engA    <= op_a;
            engB    <= op_b;
            engBusy <= 1'b1;
        end
    end

    function automatic logic [7:0] refGcd(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x;
        logic [7:0] z;
        logic [7:0] t;
        x = a;
        z = b;
        while (z != 0) begin
            t = x % z;
            x = z;
            z = t;
        end
        return x;
    endfunction

    // One clock of the main instance: records transfers seen just before the
    // edge and returns at edge+1 so inputs can be changed safely.
    task automatic applyStimulus(output logic got, output logic [7:0] val, output logic acc);
        @(negedge Clk);
        got = res_valid && res_ready;
        val = res;
        acc = in_valid && in_ready;
        if (acc) expQ.push_back(refGcd(in_a, in_b));
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        checkCount++; if (start !== 1'b0) $display("[TB] FAIL reset_start: got %b want 0", start); else passCount++;
        checkCount++; if (op_a !== 8'd0 || op_b !== 8'd0) $display("[TB] FAIL reset_ops: got %0d,%0d want 0,0", op_a, op_b); else passCount++;
        checkCount++; if (res_valid !== 1'b0) $display("[TB] FAIL reset_res_valid: got %b want 0", res_valid); else passCount++;
        checkCount++; if (res !== 8'd0) $display("[TB] FAIL reset_res: got %0d want 0", res); else passCount++;
        checkCount++; if (err !== 1'b0) $display("[TB] FAIL reset_err: got %b want 0", err); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passCount++;
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        checkCount++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); else passCount++;
    endtask

    task automatic test_basic();
        logic got, acc;
        logic [7:0] val, e;
        bit done, sawStart, prevAckStart;
        done = 0; sawStart = 0; prevAckStart = 0;
        res_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'd10; in_b = 8'd24;
        for (int n = 0; n < 200 && !done; n++) begin
            applyStimulus(got, val, acc);
            if (acc) in_valid = 1'b0;
            if (prevAckStart) begin
                checkCount++; if (start !== 1'b0) $display("[TB] FAIL basic_start_fall: got %b want 0", start); else passCount++;
            end
            prevAckStart = start && ack;
            if (start && !sawStart) begin
                sawStart = 1;
                checkCount++; if (op_a !== 8'd10) $display("[TB] FAIL basic_op_a: got %0d want 10", op_a); else passCount++;
                checkCount++; if (op_b !== 8'd24) $display("[TB] FAIL basic_op_b: got %0d want 24", op_b); else passCount++;
            end
            if (got) begin
                done = 1;
                checkCount++;
                if (expQ.size() == 0) $display("[TB] FAIL basic_res: got %0d with nothing expected", val);
                else begin
                    e = expQ.pop_front();
                    if (val !== e) $display("[TB] FAIL basic_res: got %0d want %0d", val, e); else passCount++;
                end
                checkCount++; if (err !== 1'b0) $display("[TB] FAIL basic_err: got %b want 0", err); else passCount++;
            end
        end
        if (!done) begin checkCount++; $display("[TB] FAIL basic_timeout: got no result want 1 result"); end
        if (!sawStart) begin checkCount++; $display("[TB] FAIL basic_start: got no start want a start pulse"); end
    endtask

    task automatic test_zero_bypass();
        logic got, acc;
        logic [7:0] val, e;
        logic [7:0] pa[3];
        logic [7:0] pb[3];
        int idx, nres, rises, lastN;
        bit prevStart;
        pa = '{8'd11, 8'd0, 8'd0};
        pb = '{8'd33, 8'd7, 8'd0};
        idx = 0; nres = 0; rises = 0; lastN = 0; prevStart = 0;
        res_ready = 1'b1;
        in_valid = 1'b1; in_a = pa[0]; in_b = pb[0];
        for (int n = 0; n < 300 && nres < 3; n++) begin
            applyStimulus(got, val, acc);
            if (acc) idx++;
            if (idx < 3) begin in_a = pa[idx]; in_b = pb[idx]; end
            else in_valid = 1'b0;
            if (start && !prevStart) rises++;
            prevStart = start;
            if (got) begin
                checkCount++;
                if (expQ.size() == 0) $display("[TB] FAIL zero_res: got %0d with nothing expected", val);
                else begin
                    e = expQ.pop_front();
                    if (val !== e) $display("[TB] FAIL zero_res: got %0d want %0d", val, e); else passCount++;
                end
                if (nres > 0) begin
                    checkCount++; if (n - lastN !== 2) $display("[TB] FAIL zero_gap: got %0d cycles want 2", n - lastN); else passCount++;
                end
                lastN = n;
                nres++;
            end
        end
        checkCount++; if (nres !== 3) $display("[TB] FAIL zero_count: got %0d results want 3", nres); else passCount++;
        checkCount++; if (rises !== 1) $display("[TB] FAIL zero_start_count: got %0d start pulses want 1", rises); else passCount++;
    endtask

    task automatic test_back_to_back();
        logic got, acc;
        logic [7:0] val, e;
        logic [7:0] pa[6];
        logic [7:0] pb[6];
        int idx, nres;
        pa = '{8'd12, 8'd7, 8'd5, 8'd9, 8'd14, 8'd8};
        pb = '{8'd18, 8'd21, 8'd0, 8'd6, 8'd4, 8'd8};
        idx = 0; nres = 0;
        res_ready = 1'b0;
        in_valid = 1'b1; in_a = pa[0]; in_b = pb[0];
        for (int n = 0; n < 30; n++) begin
            applyStimulus(got, val, acc);
            if (acc) idx++;
            if (idx < 6) begin in_a = pa[idx]; in_b = pb[idx]; end
            else in_valid = 1'b0;
        end
        checkCount++; if (idx !== 5) $display("[TB] FAIL b2b_accepted: got %0d want 5", idx); else passCount++;
        checkCount++; if (in_ready !== 1'b0) $display("[TB] FAIL b2b_in_ready_full: got %b want 0", in_ready); else passCount++;
        checkCount++; if (res_valid !== 1'b1) $display("[TB] FAIL b2b_res_valid: got %b want 1", res_valid); else passCount++;
        in_valid = 1'b0;
        res_ready = 1'b1;
        for (int n = 0; n < 300 && nres < 5; n++) begin
            applyStimulus(got, val, acc);
            if (got) begin
                nres++;
                checkCount++;
                if (expQ.size() == 0) $display("[TB] FAIL b2b_res: got %0d with nothing expected", val);
                else begin
                    e = expQ.pop_front();
                    if (val !== e) $display("[TB] FAIL b2b_res: got %0d want %0d", val, e); else passCount++;
                end
            end
        end
        checkCount++; if (nres !== 5) $display("[TB] FAIL b2b_drain: got %0d results want 5", nres); else passCount++;
        checkCount++; if (in_ready !== 1'b1) $display("[TB] FAIL b2b_in_ready_after: got %b want 1", in_ready); else passCount++;
    endtask

    task automatic test_long();
        logic got, acc;
        logic [7:0] val, e;
        int pushN, doneN;
        pushN = -1; doneN = -1;
        res_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'd255; in_b = 8'd1;
        for (int n = 0; n < 700 && doneN < 0; n++) begin
            applyStimulus(got, val, acc);
            if (acc) begin in_valid = 1'b0; pushN = n; end
            if (got) begin
                doneN = n;
                checkCount++;
                if (expQ.size() == 0) $display("[TB] FAIL long_res: got %0d with nothing expected", val);
                else begin
                    e = expQ.pop_front();
                    if (val !== e) $display("[TB] FAIL long_res: got %0d want %0d", val, e); else passCount++;
                end
                checkCount++; if (err !== 1'b0) $display("[TB] FAIL long_err: got %b want 0", err); else passCount++;
            end
        end
        checkCount++;
        if (doneN < 0 || doneN - pushN >= 600) $display("[TB] FAIL long_latency: got %0d cycles want under 600", doneN - pushN);
        else passCount++;
    endtask

    task automatic test_timeout();
        int rise, fall;
        rise = -1; fall = -1;
        res_ready2 = 1'b0;
        in_valid2 = 1'b1; in_a2 = 8'd5; in_b2 = 8'd10;
        @(posedge Clk);
        #1;
        in_valid2 = 1'b0;
        for (int k = 0; k < 60 && fall < 0; k++) begin
            if (start2 && rise < 0) begin
                rise = k;
                checkCount++; if (op_a2 !== 8'd5 || op_b2 !== 8'd10) $display("[TB] FAIL wd_ops: got %0d,%0d want 5,10", op_a2, op_b2); else passCount++;
            end
            if (!start2 && rise >= 0 && fall < 0) fall = k;
            if (fall < 0) begin @(posedge Clk); #1; end
        end
        checkCount++;
        if (rise < 0 || fall < 0 || fall - rise !== 16) $display("[TB] FAIL wd_start_width: got %0d cycles want 16", fall - rise);
        else passCount++;
        checkCount++; if (res_valid2 !== 1'b1) $display("[TB] FAIL wd_res_valid: got %b want 1", res_valid2); else passCount++;
        checkCount++; if (res2 !== 8'd0) $display("[TB] FAIL wd_res: got %0d want 0", res2); else passCount++;
        checkCount++; if (err2 !== 1'b1) $display("[TB] FAIL wd_err: got %b want 1", err2); else passCount++;
        checkCount++; if (in_ready2 !== 1'b0) $display("[TB] FAIL wd_in_ready: got %b want 0", in_ready2); else passCount++;
        res_ready2 = 1'b1;
        @(posedge Clk);
        #1;
        res_ready2 = 1'b0;
        checkCount++; if (res_valid2 !== 1'b0) $display("[TB] FAIL wd_res_accepted: got %b want 0", res_valid2); else passCount++;
        in_valid2 = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        in_valid2 = 1'b0;
        checkCount++; if (in_ready2 !== 1'b0 || err2 !== 1'b1 || busy2 !== 1'b1) $display("[TB] FAIL wd_sticky: got in_ready=%b err=%b busy=%b want 0,1,1", in_ready2, err2, busy2); else passCount++;
        Rst_n = 1'b0;
        #1;
        checkCount++; if (err2 !== 1'b0) $display("[TB] FAIL wd_reset_err: got %b want 0", err2); else passCount++;
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        checkCount++; if (in_ready2 !== 1'b1) $display("[TB] FAIL wd_reset_in_ready: got %b want 1", in_ready2); else passCount++;
    endtask

    task automatic test_midop_reset();
        logic got, acc;
        logic [7:0] val, e;
        logic [7:0] pa[3];
        logic [7:0] pb[3];
        int idx, startSeen, extra;
        bit ackSeen, anyStart, done;
        pa = '{8'd255, 8'd4, 8'd9};
        pb = '{8'd1, 8'd6, 8'd3};
        idx = 0; startSeen = 0; extra = 0; ackSeen = 0; anyStart = 0; done = 0;
        res_ready = 1'b1;
        in_valid = 1'b1; in_a = pa[0]; in_b = pb[0];
        for (int n = 0; n < 50 && !(idx == 3 && startSeen >= 3); n++) begin
            applyStimulus(got, val, acc);
            if (acc) idx++;
            if (idx < 3) begin in_a = pa[idx]; in_b = pb[idx]; end
            else in_valid = 1'b0;
            if (start) startSeen++;
        end
        checkCount++; if (start !== 1'b1 || busy !== 1'b1) $display("[TB] FAIL mid_pre_issue: got start=%b busy=%b want 1,1", start, busy); else passCount++;
        #2;
        Rst_n = 1'b0;
        #1;
        checkCount++; if (start !== 1'b0 || res_valid !== 1'b0 || err !== 1'b0) $display("[TB] FAIL mid_async: got start=%b res_valid=%b err=%b want 0,0,0", start, res_valid, err); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL mid_fifo_flush: got busy=%b want 0", busy); else passCount++;
        expQ.delete();
        engHold = 1'b1;
        for (int n = 0; n < 400 && !ackSeen; n++) begin
            @(posedge Clk);
            #1;
            if (ack) ackSeen = 1;
        end
        checkCount++; if (!ackSeen) $display("[TB] FAIL mid_stale_ack: got ack=0 want a stale ack"); else passCount++;
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        in_valid = 1'b1; in_a = 8'd8; in_b = 8'd12;
        applyStimulus(got, val, acc);
        in_valid = 1'b0;
        checkCount++; if (acc !== 1'b1) $display("[TB] FAIL mid_accept: got %b want 1", acc); else passCount++;
        for (int n = 0; n < 8; n++) begin
            applyStimulus(got, val, acc);
            if (start) anyStart = 1;
        end
        checkCount++; if (anyStart || busy !== 1'b1) $display("[TB] FAIL mid_wait_ack: got start_seen=%b busy=%b want 0,1", anyStart, busy); else passCount++;
        engHold = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            applyStimulus(got, val, acc);
            if (got) begin
                done = 1;
                checkCount++;
                if (expQ.size() == 0) $display("[TB] FAIL mid_res: got %0d with nothing expected", val);
                else begin
                    e = expQ.pop_front();
                    if (val !== e) $display("[TB] FAIL mid_res: got %0d want %0d", val, e); else passCount++;
                end
            end
        end
        if (!done) begin checkCount++; $display("[TB] FAIL mid_timeout: got no result want 1 result"); end
        for (int n = 0; n < 20; n++) begin
            applyStimulus(got, val, acc);
            if (got) extra++;
        end
        checkCount++; if (extra !== 0 || busy !== 1'b0) $display("[TB] FAIL mid_no_stale: got extra=%0d busy=%b want 0,0", extra, busy); else passCount++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_bypass();
        test_back_to_back();
        test_long();
        test_timeout();
        test_midop_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
